// File: rtl/maincpu_rom_reader.sv
// Read-side controller for the main-CPU program ROM BRAM (32K x 8).
// Arbitrates single-byte CPU fetches against sequential loader bursts.
module maincpu_rom_reader #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clka,
  input  logic        rsta,
  input  logic        cpu_rd,
  input  logic [15:0] cpu_addr,
  output logic        cpu_ready,
  output logic [7:0]  cpu_data,
  input  logic        burst_start,
  input  logic [14:0] burst_base,
  input  logic [7:0]  burst_len,
  output logic        burst_valid,
  output logic [7:0]  burst_data,
  output logic        burst_done,
  output logic        busy,
  output logic [14:0] addra,
  input  logic [7:0]  douta
);

  typedef enum logic [2:0] {IDLE, CWAIT, CDONE, BURST, DRAIN} state_t;

  state_t state, state_n;

  logic                  pend, pend_n;
  logic [14:0]           bbase;
  logic [7:0]            blen;
  logic [7:0]            rem;
  logic [1:0]            cnt;
  logic [READ_LATENCY:0] vpipe, lpipe;

  logic acc_cpu, acc_oor, cap_cpu, start_burst, issue_next, latch_burst;
  logic issue, last;

  always_comb begin
    state_n     = state;
    acc_cpu     = 1'b0;
    acc_oor     = 1'b0;
    cap_cpu     = 1'b0;
    start_burst = 1'b0;
    issue_next  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_rd) begin
          if (cpu_addr[15]) begin
            acc_oor = 1'b1;
            state_n = CDONE;
          end else begin
            acc_cpu = 1'b1;
            state_n = CWAIT;
          end
        end else if (pend) begin
          start_burst = 1'b1;
          state_n     = BURST;
        end
      end
      CWAIT: begin
        if (cnt == 2'(READ_LATENCY)) begin
          cap_cpu = 1'b1;
          state_n = CDONE;
        end
      end
      CDONE: state_n = IDLE;
      BURST: begin
        // rem counts addresses still to issue after the one sent on entry
        if (rem != 8'd0) issue_next = 1'b1;
        if (rem <= 8'd1) state_n = DRAIN;
      end
      DRAIN: begin
        if (vpipe == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    latch_burst = burst_start && !pend && (state != BURST) && (state != DRAIN);
    if (start_burst)      pend_n = 1'b0;
    else if (latch_burst) pend_n = 1'b1;
    else                  pend_n = pend;

    issue = start_burst | issue_next;
    last  = start_burst ? (blen == 8'd1) : (rem == 8'd1);
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state       <= IDLE;
      pend        <= 1'b0;
      bbase       <= '0;
      blen        <= '0;
      rem         <= '0;
      cnt         <= '0;
      vpipe       <= '0;
      lpipe       <= '0;
      addra       <= '0;
      cpu_ready   <= 1'b0;
      cpu_data    <= '0;
      burst_valid <= 1'b0;
      burst_data  <= '0;
      burst_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state     <= state_n;
      pend      <= pend_n;
      busy      <= (state_n != IDLE) || pend_n;
      cpu_ready <= cap_cpu | acc_oor;

      if (latch_burst) begin
        bbase <= burst_base;
        blen  <= burst_len;
      end

      if (acc_cpu)             cnt <= '0;
      else if (state == CWAIT) cnt <= cnt + 2'd1;

      if (cap_cpu)      cpu_data <= douta;
      else if (acc_oor) cpu_data <= 8'hFF;

      // burst_len of 0 wraps to rem=255, giving 256 addresses in total
      if (acc_cpu) begin
        addra <= cpu_addr[14:0];
      end else if (start_burst) begin
        addra <= bbase;
        rem   <= blen - 8'd1;
      end else if (issue_next) begin
        addra <= addra + 15'd1;
        rem   <= rem - 8'd1;
      end

      vpipe <= {vpipe[READ_LATENCY-1:0], issue};
      lpipe <= {lpipe[READ_LATENCY-1:0], issue & last};

      burst_valid <= vpipe[READ_LATENCY];
      burst_done  <= vpipe[READ_LATENCY] & lpipe[READ_LATENCY];
      if (vpipe[READ_LATENCY]) burst_data <= douta;
    end
  end

endmodule

// File: tb/tb_maincpu_rom_reader.sv
// Scoreboard bench: lane 0 runs READ_LATENCY=1, lane 1 runs READ_LATENCY=2,
// each against a ROM model douta = addra[7:0]^8'h5A.
module tb_maincpu_rom_reader;

  logic              clk = 1'b0;
  logic              rsta;
  logic [1:0]        cpu_rd;
  logic [1:0][15:0]  cpu_addr;
  logic [1:0]        cpu_ready;
  logic [1:0][7:0]   cpu_data;
  logic [1:0]        burst_start;
  logic [1:0][14:0]  burst_base;
  logic [1:0][7:0]   burst_len;
  logic [1:0]        burst_valid;
  logic [1:0][7:0]   burst_data;
  logic [1:0]        burst_done;
  logic [1:0]        busy;
  logic [1:0][14:0]  addra;
  logic [1:0][7:0]   douta;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit [1:0] busy_chk = '0;

  typedef struct {
    int         lane;
    logic [7:0] data;
    logic       done;
    int         cyc;
  } exp_t;

  exp_t cq[$];
  exp_t bq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : lane
    logic [7:0] d1, d2;
    always @(posedge clk) begin
      d1 <= addra[g][7:0] ^ 8'h5A;
      d2 <= d1;
    end
    assign douta[g] = (g == 0) ? d1 : d2;

    maincpu_rom_reader #(.READ_LATENCY(g + 1)) dut (
      .clka        (clk),
      .rsta        (rsta),
      .cpu_rd      (cpu_rd[g]),
      .cpu_addr    (cpu_addr[g]),
      .cpu_ready   (cpu_ready[g]),
      .cpu_data    (cpu_data[g]),
      .burst_start (burst_start[g]),
      .burst_base  (burst_base[g]),
      .burst_len   (burst_len[g]),
      .burst_valid (burst_valid[g]),
      .burst_data  (burst_data[g]),
      .burst_done  (burst_done[g]),
      .busy        (busy[g]),
      .addra       (addra[g]),
      .douta       (douta[g])
    );
  end

  task automatic check(input string nm, input int l, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s lane=%0d got=%0h required=%0h (cycle %0d)", nm, l, got, exp, cyc);
    end
  endtask

  // Monitor: pops expected responses whenever a lane presents output.
  always @(negedge clk) begin
    exp_t e;
    if (!rsta) begin
      for (int l = 0; l < 2; l++) begin
        if (busy_chk[l]) begin
          check("busy_after_done", l, int'(busy[l]), 0);
          busy_chk[l] = 1'b0;
        end
        if (cpu_ready[l]) begin
          if (cq.size() == 0) begin
            checks++; failures++;
            $display("FAIL cpu_unexpected lane=%0d got=%0h required=none", l, cpu_data[l]);
          end else begin
            e = cq.pop_front();
            check("cpu_lane", l, l, e.lane);
            check("cpu_data", l, int'(cpu_data[l]), int'(e.data));
            if (e.cyc >= 0) check("cpu_ready_cycle", l, cyc, e.cyc);
          end
        end
        if (burst_valid[l]) begin
          if (bq.size() == 0) begin
            checks++; failures++;
            $display("FAIL burst_unexpected lane=%0d got=%0h required=none", l, burst_data[l]);
          end else begin
            e = bq.pop_front();
            check("burst_lane", l, l, e.lane);
            check("burst_data", l, int'(burst_data[l]), int'(e.data));
            check("burst_done", l, int'(burst_done[l]), int'(e.done));
            check("burst_cycle", l, cyc, e.cyc);
          end
          if (burst_done[l]) busy_chk[l] = 1'b1;
        end else if (burst_done[l]) begin
          check("done_without_valid", l, int'(burst_done[l]), 0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_c(input int l, input logic [7:0] d, input int c);
    exp_t e;
    e.lane = l; e.data = d; e.done = 1'b0; e.cyc = c;
    cq.push_back(e);
  endtask

  task automatic push_b(input int l, input logic [14:0] base, input int n, input int s, input int rl);
    exp_t e;
    logic [14:0] a;
    for (int k = 0; k < n; k++) begin
      a = base + 15'(k);
      e.lane = l; e.data = a[7:0] ^ 8'h5A; e.done = (k == n - 1); e.cyc = s + k + rl + 1;
      bq.push_back(e);
    end
  endtask

  task automatic wait_idle(input int l, input string nm);
    int n;
    for (n = 0; n < 2000; n++) begin
      step();
      if (!busy[l] && cq.size() == 0 && bq.size() == 0) break;
    end
    if (n == 2000) begin
      checks++; failures++;
      $display("FAIL %s_timeout lane=%0d got=busy required=idle", nm, l);
    end
    step();
  endtask

  task automatic check_zero(input int l, input string nm);
    check({nm, "_cpu_ready"}, l, int'(cpu_ready[l]), 0);
    check({nm, "_cpu_data"}, l, int'(cpu_data[l]), 0);
    check({nm, "_burst_valid"}, l, int'(burst_valid[l]), 0);
    check({nm, "_burst_data"}, l, int'(burst_data[l]), 0);
    check({nm, "_burst_done"}, l, int'(burst_done[l]), 0);
    check({nm, "_busy"}, l, int'(busy[l]), 0);
    check({nm, "_addra"}, l, int'(addra[l]), 0);
  endtask

  task automatic run_lane(input int l);
    int rl, a, s, n;
    rl = l + 1;

    // back-to-back in-range reads, second held pending on the level request
    step();
    cpu_rd[l] = 1'b1; cpu_addr[l] = 16'h0123;
    a = cyc + 1;
    push_c(l, 8'h79, a + rl + 1);
    step();
    cpu_addr[l] = 16'h7FFF;
    push_c(l, 8'hA5, a + rl + 3 + rl + 1);
    repeat (rl + 3) step();
    cpu_rd[l] = 1'b0;
    check("addra_second_read", l, int'(addra[l]), 'h7FFF);
    wait_idle(l, "reads");

    // out-of-range read: no BRAM access
    cpu_rd[l] = 1'b1; cpu_addr[l] = 16'h8000;
    a = cyc + 1;
    push_c(l, 8'hFF, a);
    step();
    cpu_rd[l] = 1'b0;
    check("addra_oor_unchanged", l, int'(addra[l]), 'h7FFF);
    wait_idle(l, "oor");

    // wrapping burst
    burst_start[l] = 1'b1; burst_base[l] = 15'h7FFE; burst_len[l] = 8'd4;
    s = cyc + 2;
    push_b(l, 15'h7FFE, 4, s, rl);
    step();
    burst_start[l] = 1'b0;
    check("busy_pending", l, int'(busy[l]), 1);
    wait_idle(l, "wrap_burst");

    // 256-byte burst with a dropped mid-burst start
    burst_start[l] = 1'b1; burst_base[l] = 15'h0100; burst_len[l] = 8'd0;
    s = cyc + 2;
    push_b(l, 15'h0100, 256, s, rl);
    step();
    burst_start[l] = 1'b0;
    repeat (20) step();
    burst_start[l] = 1'b1; burst_base[l] = 15'h0000; burst_len[l] = 8'd3;
    step();
    burst_start[l] = 1'b0;
    wait_idle(l, "long_burst");

    // simultaneous CPU read and burst start; then a CPU read stalled by the burst
    cpu_rd[l] = 1'b1; cpu_addr[l] = 16'h0010;
    burst_start[l] = 1'b1; burst_base[l] = 15'h0000; burst_len[l] = 8'd2;
    a = cyc + 1;
    s = a + rl + 3;
    push_c(l, 8'h4A, a + rl + 1);
    push_b(l, 15'h0000, 2, s, rl);
    step();
    cpu_rd[l] = 1'b0; burst_start[l] = 1'b0;
    while (cyc < s) step();
    cpu_rd[l] = 1'b1; cpu_addr[l] = 16'h0020;
    push_c(l, 8'h7A, s + 2 * rl + 5);
    for (n = 0; n < 100; n++) begin
      step();
      if (cpu_ready[l]) break;
    end
    if (n == 100) begin
      checks++; failures++;
      $display("FAIL stalled_read_timeout lane=%0d got=no_ready required=ready", l);
    end
    cpu_rd[l] = 1'b0;
    wait_idle(l, "stall");

    // reset in the middle of a burst aborts it silently
    burst_start[l] = 1'b1; burst_base[l] = 15'h0200; burst_len[l] = 8'd50;
    s = cyc + 2;
    push_b(l, 15'h0200, 50, s, rl);
    step();
    burst_start[l] = 1'b0;
    repeat (10) step();
    #1 rsta = 1'b1;
    #1;
    check_zero(l, "midreset");
    bq.delete();
    step();
    rsta = 1'b0;
    repeat (20) step();
    check("busy_after_abort", l, int'(busy[l]), 0);
    check("cq_empty", l, cq.size(), 0);
    check("bq_empty", l, bq.size(), 0);
  endtask

  initial begin
    rsta = 1'b1;
    cpu_rd = '0; cpu_addr = '0;
    burst_start = '0; burst_base = '0; burst_len = '0;
    repeat (3) step();
    check_zero(0, "reset");
    check_zero(1, "reset");
    rsta = 1'b0;
    repeat (2) step();
    check("post_reset_busy", 0, int'(busy[0]), 0);
    check("post_reset_busy", 1, int'(busy[1]), 0);
    run_lane(0);
    run_lane(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/maincpu_rom_reader.md
# maincpu_rom_reader

Read-side controller for the main-CPU program ROM block RAM (32K x 8, synchronous read). It arbitrates two requesters: single-byte CPU fetches with a ready handshake, and sequential burst reads for the loader/checksum path. It drives the BRAM address port and captures its registered data output, accounting for the configured BRAM read latency. It sits between the CPU bus decode and the `maincpu` BRAM instance.

## Interface
- READ_LATENCY, 1, BRAM cycles from address sampled to douta valid (legal 1 or 2)
- clka  in  1  system clock, all logic on rising edge
- rsta  in  1  asynchronous, active-high reset
- cpu_rd  in  1  CPU read request (level), sampled only in IDLE
- cpu_addr  in  16  CPU byte address
- cpu_ready  out  1  one-cycle pulse: cpu_data valid, request complete
- cpu_data  out  8  read data, held until next CPU completion
- burst_start  in  1  one-cycle pulse requesting a burst
- burst_base  in  15  first ROM address of burst
- burst_len  in  8  byte count, 0 encodes 256
- burst_valid  out  1  burst_data valid this cycle
- burst_data  out  8  streamed byte
- burst_done  out  1  high with the last burst_valid of a burst
- busy  out  1  high when state != IDLE or a burst is pending
- addra  out  15  BRAM address (registered)
- douta  in  8  BRAM read data

## Operation
- Reset: state IDLE; addra=0, cpu_ready=0, cpu_data=0, burst_valid=0, burst_data=0, burst_done=0, busy=0, pending flag and pipeline valids cleared. Reset mid-operation aborts everything; no ready/done is ever issued for an aborted transfer.
- States: IDLE, CWAIT, CDONE, BURST, DRAIN.
- IDLE, cpu_rd=1, cpu_addr[15]=0: addra<=cpu_addr[14:0], go CWAIT for READ_LATENCY+1 cycles, capture douta into cpu_data, go CDONE.
- IDLE, cpu_rd=1, cpu_addr[15]=1 (out of ROM range): no BRAM access; cpu_data<=8'hFF, go CDONE next edge.
- CDONE: cpu_ready=1 for exactly this cycle; cpu_rd ignored; next state IDLE unconditionally.
- burst_start is latched (base, len, pending=1) whenever no burst is pending or active; burst_start while pending/active is dropped.
- IDLE priority: cpu_rd beats pending burst. Simultaneous cpu_rd and burst_start: CPU read executes, burst latched and started after CDONE.
- BURST: one address per cycle, addra = base, base+1, ...; 15-bit wrap 7FFF->0000. After len addresses go DRAIN. A valid shift register of depth READ_LATENCY+1 tags each issued address.
- DRAIN: wait until the valid pipe is empty, then IDLE. cpu_rd arriving during BURST/DRAIN stalls (cpu_ready withheld) until IDLE.
- burst_done asserted with the final burst_valid only; pending cleared when BURST entered.

## Timing
- CPU in-range read accepted at edge N: addra valid after N; cpu_data/cpu_ready valid in the cycle after edge N+READ_LATENCY+1; IDLE again after edge N+READ_LATENCY+2. Earliest next accept is edge N+READ_LATENCY+3, i.e. 4 cycles per read at latency 1.
- Out-of-range read: cpu_ready in the cycle after the accept edge (1-cycle latency).
- Burst entered at edge S: address k on addra after edge S+k; burst_data for address k valid in the cycle after edge S+k+READ_LATENCY+1; burst_valid contiguous for len cycles; busy low the cycle after the last burst_valid.
- All outputs registered; no combinational path from any input to any output.

## Test plan
- ROM model douta = addra[7:0]^8'h5A, latency 1. cpu_rd at 16'h0123 -> cpu_ready one cycle, 3 cycles after accept, cpu_data=8'h79; second read 16'h7FFF back-to-back -> 8'hA5, accept 4 cycles after the first.
- cpu_rd at 16'h8000 -> cpu_data=8'hFF, cpu_ready the cycle after accept, addra unchanged.
- burst base=15'h7FFE, len=4 -> burst_data A4,A5,5A,5B on 4 consecutive cycles (wrap), burst_done with 5B, busy then 0.
- burst_len=0 -> 256 valid bytes, single burst_done on the 256th; burst_start mid-burst ignored.
- Same-cycle cpu_rd(16'h0010) and burst_start(base 0, len 2) -> cpu_ready with 8'h4A first, then burst 5A,5B; cpu_rd raised during the burst stalls until drain.
- rsta pulsed mid-burst -> all outputs 0 immediately, no burst_done; repeat all of the above with READ_LATENCY=2, every latency one cycle longer.
